// File: rtl/reg_pair_sequencer_if.sv
// Request/response and register-file port bundle for reg_pair_sequencer.
//   req_*        : valid/ready request channel (op, pair, 16-bit load data)
//   done, result : completion pulse and final pair value
//   rf_out*_sel  : read selects (high/low byte of latched pair), rf_out* read data
//   rf_data_in*  : write data/select, rf_write_reg write enable
// slave modport is the sequencer's view; master is the requester/register-file side.
interface reg_pair_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic [15:0] req_data;
  logic [2:0]  rf_out1_sel;
  logic [2:0]  rf_out2_sel;
  logic [7:0]  rf_out1;
  logic [7:0]  rf_out2;
  logic [7:0]  rf_data_in;
  logic [2:0]  rf_data_in_sel;
  logic        rf_write_reg;
  logic        done;
  logic [15:0] result;

  modport slave (
    input  req_valid, req_op, req_pair, req_data, rf_out1, rf_out2,
    output req_ready, rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel,
           rf_write_reg, done, result
  );

  modport master (
    output req_valid, req_op, req_pair, req_data, rf_out1, rf_out2,
    input  req_ready, rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel,
           rf_write_reg, done, result
  );
endinterface

// File: rtl/reg_pair_sequencer.sv
// Write-side sequencer for 16-bit register-pair operations (LD rr,nn / INC rr / DEC rr)
// on BC, DE, HL of an 8-bit register file with one write port.
// Ports:
//   clock  : system clock, all state on posedge
//   reset  : asynchronous, active-high
//   bus    : reg_pair_sequencer_if.slave (request channel, rf read/write port, done/result)
// Parameter WRITE_HIGH_FIRST: 0 writes low byte then high byte, 1 the reverse.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// READ  | rf read selects point at latched pair; capture value +/- 1
// WR_A  | first byte write
// WR_B  | second byte write
// DONE  | one-cycle completion pulse, result valid
module reg_pair_sequencer #(
  parameter bit WRITE_HIGH_FIRST = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  reg_pair_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WR_A = 3'd2,
    WR_B = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_INC   = 2'd1;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] PAIR_RSVD = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  pair_q, pair_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] value_q, value_d;
  logic [15:0] result_q, result_d;

  logic [2:0]  hi_sel;
  logic [2:0]  lo_sel;
  logic [15:0] rd_value;
  logic        write_lo;

  assign hi_sel   = {pair_q, 1'b0};
  assign lo_sel   = {pair_q, 1'b1};
  assign rd_value = {bus.rf_out1, bus.rf_out2};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pair_q   <= 2'd0;
      op_q     <= 2'd0;
      value_q  <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pair_q   <= pair_d;
      op_q     <= op_d;
      value_q  <= value_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pair_d             = pair_q;
    op_d               = op_q;
    value_d            = value_q;
    result_d           = result_q;
    write_lo           = 1'b0;
    bus.rf_write_reg   = 1'b0;
    bus.rf_data_in     = 8'h00;
    bus.rf_data_in_sel = 3'd0;

    case (state_q)
      IDLE: begin
        // req_ready is high only here, so req_valid alone means accept.
        if (bus.req_valid) begin
          op_d   = bus.req_op;
          pair_d = bus.req_pair;
          if (bus.req_op == OP_RSVD || bus.req_pair == PAIR_RSVD) begin
            result_d = 16'h0000;
            state_d  = DONE;
          end else if (bus.req_op == OP_LOAD) begin
            value_d = bus.req_data;
            state_d = WR_A;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        value_d = (op_q == OP_INC) ? rd_value + 16'h0001 : rd_value - 16'h0001;
        state_d = WR_A;
      end
      WR_A: begin
        write_lo         = ~WRITE_HIGH_FIRST;
        bus.rf_write_reg = 1'b1;
        state_d          = WR_B;
      end
      WR_B: begin
        write_lo         = WRITE_HIGH_FIRST;
        bus.rf_write_reg = 1'b1;
        result_d         = value_q;
        state_d          = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.rf_write_reg) begin
      bus.rf_data_in     = write_lo ? value_q[7:0] : value_q[15:8];
      bus.rf_data_in_sel = write_lo ? lo_sel : hi_sel;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.rf_out1_sel = hi_sel;
  assign bus.rf_out2_sel = lo_sel;

endmodule
